sfp_frame_link: RTL and testbench

Frame-level transceiver between the AXI register/control slave and the SFP serial core (Aurora-style AXI4-Stream user interface). It serializes a fully assembled C_DATA_FRAME_BIT-wide frame into AXI4-Stream beats when the control slave pulses its start flag. In the receive direction it deserializes incoming beats back into a frame, validates it, and raises a one-cycle end flag. Its outputs drive the control slave's `i_tx_en`, `i_sfp_end_flag` and `i_master_stream_data` inputs.

---
 rtl/sfp_link_pkg.sv | 27 ++
 rtl/sfp_link_rx_deser.sv | 113 +++++++++++
 rtl/sfp_frame_link.sv | 149 ++++++++++++++
 tb/tb_sfp_frame_link.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_link_pkg.sv
// Shared types, frame field offsets and checksum helper for the SFP frame link.
// Optional feature macro: SFP_FRAME_CHECKSUM_EN (appends/validates a 32-bit sum beat).
package sfp_link_pkg;

    typedef enum logic [1:0] {TxIdle, TxSend, TxCsum, TxDone} tx_state_t;
    typedef enum logic [1:0] {RxIdle, RxRecv, RxDrop} rx_state_t;

    localparam int unsigned CMD_MSB        = 127;
    localparam int unsigned SLV_ID_MSB     = 111;
    localparam int unsigned DATA_1_MSB     = 95;
    localparam int unsigned DATA_2_MSB     = 63;
    localparam int unsigned DATA_3_MSB     = 31;
    localparam int unsigned CSUM_BITS      = 32;
    localparam int unsigned MAX_FRAME_BITS = 1024;

    // Modulo-2^32 sum of the lowest n_words 32-bit words of a zero-extended frame.
    function automatic logic [CSUM_BITS-1:0] frame_sum(input logic [MAX_FRAME_BITS-1:0] words,
                                                       input int unsigned n_words);
        logic [CSUM_BITS-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < MAX_FRAME_BITS / CSUM_BITS; i++) begin
            if (i < n_words) sum = sum + words[i*CSUM_BITS +: CSUM_BITS];
        end
        return sum;
    endfunction

endpackage

// File: rtl/sfp_link_rx_deser.sv
// Receive deserializer/checker: assembles stream beats into a frame, validates length
// (and the checksum beat when SFP_FRAME_CHECKSUM_EN is defined), counts discarded frames.
module sfp_link_rx_deser
    import sfp_link_pkg::*;
#(
    parameter int unsigned C_DATA_FRAME_BIT  = 128,
    parameter int unsigned C_AXIS_DATA_WIDTH = 32
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic [C_AXIS_DATA_WIDTH-1:0] i_tdata,
    input  logic                         i_tvalid,
    input  logic                         i_tlast,
    output logic                         o_tready,
    output logic [C_DATA_FRAME_BIT-1:0]  o_rx_frame,
    output logic                         o_rx_end_flag,
    output logic [15:0]                  o_rx_err_cnt
);

    localparam int unsigned N = C_DATA_FRAME_BIT / C_AXIS_DATA_WIDTH;
`ifdef SFP_FRAME_CHECKSUM_EN
    localparam int unsigned NRX = N + 1;
`else
    localparam int unsigned NRX = N;
`endif
    localparam int unsigned CntW = $clog2(NRX + 1);

    rx_state_t                   state_q, state_d;
    logic [C_DATA_FRAME_BIT-1:0] asm_q, asm_d, frame_q, frame_d, shifted;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        end_q, end_d, rdy_q, rdy_d, hs, err_inc;
    logic [15:0]                 err_q, err_d;

    assign hs      = i_tvalid & rdy_q;
    assign shifted = {asm_q[C_DATA_FRAME_BIT-C_AXIS_DATA_WIDTH-1:0], i_tdata};

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        end_d   = 1'b0;
        rdy_d   = 1'b1;
        err_inc = 1'b0;
        case (state_q)
            RxIdle, RxRecv: begin
                if (hs) begin
                    if (cnt_q == CntW'(NRX - 1)) begin
                        cnt_d   = '0;
                        state_d = RxIdle;
                        if (i_tlast) begin
`ifdef SFP_FRAME_CHECKSUM_EN
                            if (i_tdata == C_AXIS_DATA_WIDTH'(frame_sum(
                                    MAX_FRAME_BITS'(asm_q), C_DATA_FRAME_BIT / CSUM_BITS))) begin
                                frame_d = asm_q;
                                end_d   = 1'b1;
                            end else begin
                                err_inc = 1'b1;
                            end
`else
                            frame_d = shifted;
                            end_d   = 1'b1;
`endif
                        end else begin
                            // Overlong frame: swallow the rest up to its TLAST.
                            state_d = RxDrop;
                            err_inc = 1'b1;
                        end
                    end else if (i_tlast) begin
                        cnt_d   = '0;
                        state_d = RxIdle;
                        err_inc = 1'b1;
                    end else begin
                        asm_d   = shifted;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RxRecv;
                    end
                end
            end
            RxDrop: begin
                if (hs && i_tlast) state_d = RxIdle;
            end
            default: state_d = RxIdle;
        endcase
        err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= RxIdle;
            asm_q   <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign o_tready      = rdy_q;
    assign o_rx_frame    = frame_q;
    assign o_rx_end_flag = end_q;
    assign o_rx_err_cnt  = err_q;

endmodule

// File: rtl/sfp_frame_link.sv
// Frame-level SFP link: TX serializer FSM plus the RX deserializer instance.
// Optional feature macro: SFP_FRAME_CHECKSUM_EN (extra checksum beat per frame).
module sfp_frame_link
    import sfp_link_pkg::*;
#(
    parameter int unsigned C_DATA_FRAME_BIT  = 128,
    parameter int unsigned C_AXIS_DATA_WIDTH = 32
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         i_sfp_start_flag,
    input  logic [C_DATA_FRAME_BIT-1:0]  i_tx_frame,
    output logic                         o_tx_done,
    output logic                         o_tx_busy,
    output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                         M_AXIS_TVALID,
    output logic                         M_AXIS_TLAST,
    input  logic                         M_AXIS_TREADY,
    input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                         S_AXIS_TVALID,
    input  logic                         S_AXIS_TLAST,
    output logic                         S_AXIS_TREADY,
    output logic [C_DATA_FRAME_BIT-1:0]  o_rx_frame,
    output logic                         o_rx_end_flag,
    output logic [15:0]                  o_rx_err_cnt
);

    localparam int unsigned N    = C_DATA_FRAME_BIT / C_AXIS_DATA_WIDTH;
    localparam int unsigned CntW = $clog2(N + 1);

    tx_state_t                   state_q, state_d;
    logic [C_DATA_FRAME_BIT-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        tvalid_q, tvalid_d, tlast_q, tlast_d, done_q, done_d;
`ifdef SFP_FRAME_CHECKSUM_EN
    logic [CSUM_BITS-1:0]        csum_q, csum_d;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
`ifdef SFP_FRAME_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            TxIdle: begin
                if (i_sfp_start_flag) begin
                    state_d  = TxSend;
                    shreg_d  = i_tx_frame;
                    cnt_d    = '0;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
`ifdef SFP_FRAME_CHECKSUM_EN
                    csum_d   = frame_sum(MAX_FRAME_BITS'(i_tx_frame),
                                         C_DATA_FRAME_BIT / CSUM_BITS);
`endif
                end
            end
            TxSend: begin
                if (M_AXIS_TREADY) begin
                    shreg_d = shreg_q << C_AXIS_DATA_WIDTH;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntW'(N - 1)) begin
`ifdef SFP_FRAME_CHECKSUM_EN
                        state_d  = TxCsum;
                        tlast_d  = 1'b1;
`else
                        state_d  = TxDone;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
`endif
                    end else begin
`ifdef SFP_FRAME_CHECKSUM_EN
                        tlast_d = 1'b0;
`else
                        tlast_d = (cnt_q == CntW'(N - 2));
`endif
                    end
                end
            end
            TxCsum: begin
                if (M_AXIS_TREADY) begin
                    state_d  = TxDone;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    done_d   = 1'b1;
                end
            end
            TxDone:  state_d = TxIdle;
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q  <= TxIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SFP_FRAME_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
`ifdef SFP_FRAME_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

`ifdef SFP_FRAME_CHECKSUM_EN
    assign M_AXIS_TDATA = (state_q == TxCsum) ? C_AXIS_DATA_WIDTH'(csum_q)
                                              : shreg_q[C_DATA_FRAME_BIT-1 -: C_AXIS_DATA_WIDTH];
`else
    assign M_AXIS_TDATA = shreg_q[C_DATA_FRAME_BIT-1 -: C_AXIS_DATA_WIDTH];
`endif
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign o_tx_done     = done_q;
    assign o_tx_busy     = (state_q != TxIdle);

    sfp_link_rx_deser #(
        .C_DATA_FRAME_BIT (C_DATA_FRAME_BIT),
        .C_AXIS_DATA_WIDTH(C_AXIS_DATA_WIDTH)
    ) u_rx_deser (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .i_tdata      (S_AXIS_TDATA),
        .i_tvalid     (S_AXIS_TVALID),
        .i_tlast      (S_AXIS_TLAST),
        .o_tready     (S_AXIS_TREADY),
        .o_rx_frame   (o_rx_frame),
        .o_rx_end_flag(o_rx_end_flag),
        .o_rx_err_cnt (o_rx_err_cnt)
    );

endmodule

// File: tb/tb_sfp_frame_link.sv
// Directed self-checking bench for sfp_frame_link (TX serializer and RX deserializer).
module tb_sfp_frame_link;

    localparam int unsigned FB = 128;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
`ifdef SFP_FRAME_CHECKSUM_EN
    localparam int unsigned NB = N + 1;
`else
    localparam int unsigned NB = N;
`endif

    logic          clk, rstn;
    logic          start;
    logic [FB-1:0] tx_frame;
    logic          tx_done, tx_busy;
    logic [W-1:0]  m_tdata, s_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic          s_tvalid, s_tlast, s_tready;
    logic [FB-1:0] rx_frame;
    logic          rx_end;
    logic [15:0]   rx_err;

    int checks = 0;
    int errors = 0;

    sfp_frame_link #(
        .C_DATA_FRAME_BIT (FB),
        .C_AXIS_DATA_WIDTH(W)
    ) dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rstn),
        .i_sfp_start_flag(start),
        .i_tx_frame      (tx_frame),
        .o_tx_done       (tx_done),
        .o_tx_busy       (tx_busy),
        .M_AXIS_TDATA    (m_tdata),
        .M_AXIS_TVALID   (m_tvalid),
        .M_AXIS_TLAST    (m_tlast),
        .M_AXIS_TREADY   (m_tready),
        .S_AXIS_TDATA    (s_tdata),
        .S_AXIS_TVALID   (s_tvalid),
        .S_AXIS_TLAST    (s_tlast),
        .S_AXIS_TREADY   (s_tready),
        .o_rx_frame      (rx_frame),
        .o_rx_end_flag   (rx_end),
        .o_rx_err_cnt    (rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_beat(input logic [W-1:0] d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        tick();
    endtask

    task automatic rx_idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    logic [W-1:0] txw [5];
    logic [W-1:0] rxw [5];
    logic [W-1:0] rxw2[5];
    logic         pat [12];
    int           idx;

    initial begin
        txw  = '{32'h00010002, 32'h11111111, 32'h22222222, 32'h33333333, 32'h66676668};
        rxw  = '{32'h00001111, 32'h00000002, 32'hAAAA0000, 32'h0000BBBB, 32'hAAAACCCE};
        rxw2 = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hACF13567};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rstn = 1'b0; start = 1'b0; tx_frame = '0; m_tready = 1'b1;
        rx_idle();
        #12;
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_tvalid",   128'(m_tvalid), 128'(0));
        chk("rst_tx_done",  128'(tx_done),  128'(0));
        chk("rst_tx_busy",  128'(tx_busy),  128'(0));
        chk("rst_rx_frame", 128'(rx_frame), 128'(0));
        chk("rst_rx_end",   128'(rx_end),   128'(0));
        chk("rst_rx_err",   128'(rx_err),   128'(0));
        rstn = 1'b1;
        tick();
        chk("s_tready_after_rst", 128'(s_tready), 128'(1));

        // Basic TX with TREADY held high.
        start = 1'b1;
        tx_frame = 128'h0001_0002_11111111_22222222_33333333;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            chk($sformatf("tx_valid_%0d", i), 128'(m_tvalid), 128'(1));
            chk($sformatf("tx_data_%0d", i),  128'(m_tdata),  128'(txw[i]));
            chk($sformatf("tx_last_%0d", i),  128'(m_tlast),  128'(i == int'(NB) - 1));
            chk($sformatf("tx_done_early_%0d", i), 128'(tx_done), 128'(0));
            tick();
        end
        chk("tx_done_pulse",   128'(tx_done),  128'(1));
        chk("tx_valid_in_done", 128'(m_tvalid), 128'(0));
        tick();
        chk("tx_done_cleared", 128'(tx_done), 128'(0));
        chk("tx_busy_idle",    128'(tx_busy), 128'(0));

        // TX with backpressure and an ignored mid-frame start pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        for (int k = 0; k < 30 && idx < int'(NB); k++) begin
            m_tready = (k < 12) ? pat[k] : 1'b1;
            start    = (k == 2);
            chk($sformatf("bp_valid_%0d", k), 128'(m_tvalid), 128'(1));
            chk($sformatf("bp_data_%0d", k),  128'(m_tdata),  128'(txw[idx]));
            chk($sformatf("bp_last_%0d", k),  128'(m_tlast),  128'(idx == int'(NB) - 1));
            chk($sformatf("bp_done_%0d", k),  128'(tx_done),  128'(0));
            if (m_tready) idx++;
            tick();
        end
        start = 1'b0;
        m_tready = 1'b1;
        chk("bp_beat_count", 128'(idx),     128'(NB));
        chk("bp_done_pulse", 128'(tx_done), 128'(1));
        tick();
        chk("bp_done_cleared", 128'(tx_done),  128'(0));
        chk("bp_no_queued_tx", 128'(m_tvalid), 128'(0));
        tick();
        chk("bp_idle_valid", 128'(m_tvalid), 128'(0));
        chk("bp_idle_busy",  128'(tx_busy),  128'(0));

        // RX good frame.
        for (int i = 0; i < int'(NB); i++) rx_beat(rxw[i], i == int'(NB) - 1);
        rx_idle();
        chk("rx_good_frame", 128'(rx_frame), 128'h00001111_00000002_AAAA0000_0000BBBB);
        chk("rx_good_end",   128'(rx_end),   128'(1));
        chk("rx_good_err",   128'(rx_err),   128'(0));
        tick();
        chk("rx_end_one_cycle", 128'(rx_end), 128'(0));

        // Short frame: 3 beats, TLAST on the 3rd.
        for (int i = 0; i < 3; i++) begin
            rx_beat(32'hDEAD0000 + 32'(i), i == 2);
            chk($sformatf("rx_short_end_%0d", i), 128'(rx_end), 128'(0));
        end
        rx_idle();
        chk("rx_short_err",   128'(rx_err),   128'(1));
        chk("rx_short_frame", 128'(rx_frame), 128'h00001111_00000002_AAAA0000_0000BBBB);

        // Long frame: 6 beats, TLAST on the 6th.
        for (int i = 0; i < 6; i++) begin
            rx_beat(32'hBEEF0000 + 32'(i), i == 5);
            chk($sformatf("rx_long_end_%0d", i), 128'(rx_end), 128'(0));
        end
        rx_idle();
        chk("rx_long_err",   128'(rx_err),   128'(2));
        chk("rx_long_frame", 128'(rx_frame), 128'h00001111_00000002_AAAA0000_0000BBBB);

        // Good frame after errors.
        for (int i = 0; i < int'(NB); i++) rx_beat(rxw2[i], i == int'(NB) - 1);
        rx_idle();
        chk("rx_recover_frame", 128'(rx_frame), 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0);
        chk("rx_recover_end",   128'(rx_end),   128'(1));
        chk("rx_recover_err",   128'(rx_err),   128'(2));
        tick();

`ifdef SFP_FRAME_CHECKSUM_EN
        // Corrupted checksum beat.
        for (int i = 0; i < int'(N); i++) rx_beat(rxw[i], 1'b0);
        rx_beat(32'h0, 1'b1);
        rx_idle();
        chk("rx_csum_err",   128'(rx_err),   128'(3));
        chk("rx_csum_end",   128'(rx_end),   128'(0));
        chk("rx_csum_frame", 128'(rx_frame), 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0);
        tick();
`endif

        // Reset in the middle of an RX frame.
        rx_beat(rxw[0], 1'b0);
        rx_beat(rxw[1], 1'b0);
        rx_idle();
        rstn = 1'b0;
        #2;
        chk("mid_rst_tready", 128'(s_tready), 128'(0));
        chk("mid_rst_err",    128'(rx_err),   128'(0));
        chk("mid_rst_frame",  128'(rx_frame), 128'(0));
        rstn = 1'b1;
        tick();
        chk("post_rst_tready", 128'(s_tready), 128'(1));
        for (int i = 0; i < int'(NB); i++) rx_beat(rxw[i], i == int'(NB) - 1);
        rx_idle();
        chk("post_rst_frame", 128'(rx_frame), 128'h00001111_00000002_AAAA0000_0000BBBB);
        chk("post_rst_end",   128'(rx_end),   128'(1));
        chk("post_rst_err",   128'(rx_err),   128'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
